// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-memory loader; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte check
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
    logic [7:0] sum;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    state_t          state;
    logic [ADDR_W:0] len_r, cnt, cnt_nx;
    logic [1:0]      idx;
    logic            acc;
    assign acc      = in_valid & in_ready;
    assign cnt_nx   = cnt + 1'b1;
    assign cpu_hold = busy;
`ifndef IMEM_LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif
    // load sequencer: all outputs registered alongside the state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_r     <= '0;
            cnt       <= '0;
            idx       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len_r    <= (len > MAX_LEN) ? MAX_LEN : len;
                    cnt      <= '0;
                    idx      <= '0;
                    mem_addr <= '0;
                    busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum      <= '0;
                    err      <= 1'b0;
`endif
                    if (len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                RECV: if (acc) begin
                    mem_wdata[{idx, 3'b000} +: 8] <= in_data;
                    idx <= idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum <= sum + in_data;
`endif
                    if (idx == 2'd3) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                    end
                end
                WRITE: begin
                    cnt <= cnt_nx;
                    if (cnt_nx == len_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CHECK;
                        in_ready <= 1'b1;
`else
                        state    <= DONE;
                        done     <= 1'b1;
`endif
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // checksum byte must bring the total byte sum to zero mod 256
                CHECK: if (acc) begin
                    err      <= (in_data + sum) != 8'd0;
                    state    <= DONE;
                    done     <= 1'b1;
                    in_ready <= 1'b0;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
